fa8_chain_seq: RTL

//   Multi-precision add sequencer built around one shared bit_FA8 instance.

---
 rtl/fa8_chain_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fa8_chain_seq.sv
// fa8_chain_seq: multi-precision adder that reuses one 8-bit adder (bit_FA8),
// processing one byte-wide chunk per clock, LSB chunk first, with the carry
// held in a register between chunks. Start/busy/done handshake.
// Optional feature macro: FA8_SEQ_SUB_EN adds a `sub` input selecting a - b.

// 8-bit adder with carry in; s[8] is the carry out.
module bit_FA8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [8:0] s
);
    assign s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module fa8_chain_seq #(
    parameter int NUM_CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*NUM_CHUNKS-1:0] a,
    input  logic [8*NUM_CHUNKS-1:0] b,
    input  logic                    cin,
`ifdef FA8_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [8*NUM_CHUNKS-1:0] sum,
    output logic                    cout
);
    localparam int W     = 8 * NUM_CHUNKS;
    localparam int IDX_W = $clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Operand B and initial carry as loaded on an accepted start.
    // Subtraction is a + ~b + 1, so B is stored already inverted.
    logic [W-1:0]     b_start_d;
    logic             carry_start_d;

`ifdef FA8_SEQ_SUB_EN
    assign b_start_d     = sub ? ~b : b;
    assign carry_start_d = sub ? 1'b1 : cin;
`else
    assign b_start_d     = b;
    assign carry_start_d = cin;
`endif

    // Chunk currently presented to the shared adder.
    logic [7:0] a_chunk;
    logic [7:0] b_chunk;
    logic [8:0] fa_s;

    assign a_chunk = a_q[8*idx_q +: 8];
    assign b_chunk = b_q[8*idx_q +: 8];

    bit_FA8 u_fa (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_q),
        .s   (fa_s)
    );

    // Sequencer: latch on start, one chunk per cycle in RUN, one-cycle done.
    // Latched operands carry no reset; they are only read while in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_start_d;
                        carry_q <= carry_start_d;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[8*idx_q +: 8] <= fa_s[7:0];
                    carry_q             <= fa_s[8];
                    if (idx_q == LAST_IDX) begin
                        // Hold idx at the top chunk rather than wrapping.
                        cout_q  <= fa_s[8];
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
